conv1d_acc_requant: RTL and testbench

Streaming accumulate-and-requantize stage on the consumer side of the conv1d 16x16 signed multiplier. It accepts the 32-bit signed products one per cycle and sums KSIZE products plus a bias into one output point. It then rounds, shifts, saturates and optionally applies ReLU to return a 16-bit signed result to the feature-map datapath. It narrows each group of KSIZE products back to the 16-bit datapath width.

---
 rtl/conv1d_acc_requant_if.sv | 26 ++
 rtl/conv1d_acc_requant.sv | 128 ++++++++++++
 tb/tb_conv1d_acc_requant.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv1d_acc_requant_if.sv
// Stream bundle between the conv1d multiplier, the accumulate/requantize
// stage and the feature-map datapath: product input, bias, result output and
// the sticky saturation status.
interface conv1d_acc_requant_if;
  logic signed [31:0] prod_tdata;
  logic               prod_tvalid;
  logic               prod_tready;
  logic signed [31:0] bias;
  logic signed [15:0] out_tdata;
  logic               out_tvalid;
  logic               out_tready;
  logic               sat_flag;
  logic               sat_clr;

  // Accumulate/requantize stage side.
  modport slave (
    input  prod_tdata, prod_tvalid, bias, out_tready, sat_clr,
    output prod_tready, out_tdata, out_tvalid, sat_flag
  );

  // Producer/consumer side driving the stage.
  modport master (
    output prod_tdata, prod_tvalid, bias, out_tready, sat_clr,
    input  prod_tready, out_tdata, out_tvalid, sat_flag
  );
endinterface

// File: rtl/conv1d_acc_requant.sv
// Sums KSIZE signed 32-bit products plus a bias into one point, then rounds
// (half-up), shifts, saturates to 16 bits and optionally applies ReLU.
module conv1d_acc_requant #(
  parameter int KSIZE     = 5,
  parameter int ACC_WIDTH = 40,
  parameter int SHIFT     = 8,
  parameter int RELU      = 1
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  conv1d_acc_requant_if.slave     bus
);

  localparam int CNT_W = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  // One extra bit so adding the rounding constant can never wrap.
  localparam int RW    = ACC_WIDTH + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KSIZE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic signed [RW-1:0] RND_ADD =
    (SHIFT > 0) ? ({{(RW-1){1'b0}}, 1'b1} << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : '0;
  localparam logic signed [RW-1:0] SAT_MAX = RW'(32'sd32767);
  localparam logic signed [RW-1:0] SAT_MIN = RW'(-32'sd32768);

  logic [CNT_W-1:0]            cnt_r;
  logic signed [ACC_WIDTH-1:0] acc_r;
  logic signed [15:0]          out_data_r;
  logic                        out_valid_r;
  logic                        sat_flag_r;

  logic                        last_s;
  logic                        ready_s;
  logic                        accept_s;
  logic                        load_s;
  logic signed [ACC_WIDTH-1:0] prod_ext_s;
  logic signed [ACC_WIDTH-1:0] bias_ext_s;
  logic signed [ACC_WIDTH-1:0] acc_next_s;
  logic signed [RW-1:0]        rnd_s;
  logic signed [RW-1:0]        r_s;
  logic                        sat_pos_s;
  logic                        sat_neg_s;
  logic signed [15:0]          clip_s;
  logic signed [15:0]          q_s;

  // A final product only stalls while an undrained result is still held.
  assign last_s      = (cnt_r == CNT_LAST);
  assign ready_s     = ap_rst_n && !(last_s && out_valid_r && !bus.out_tready);
  assign accept_s    = bus.prod_tvalid && ready_s;
  assign load_s      = accept_s && last_s;
  assign prod_ext_s  = {{(ACC_WIDTH-32){bus.prod_tdata[31]}}, bus.prod_tdata};
  assign bias_ext_s  = {{(ACC_WIDTH-32){bus.bias[31]}}, bus.bias};

  assign bus.prod_tready = ready_s;
  assign bus.out_tdata   = out_data_r;
  assign bus.out_tvalid  = out_valid_r;
  assign bus.sat_flag    = sat_flag_r;

  // Next accumulator value: bias seeds the first term of every group.
  always_comb begin
    if (cnt_r == CNT_ZERO) begin
      acc_next_s = bias_ext_s + prod_ext_s;
    end else begin
      acc_next_s = acc_r + prod_ext_s;
    end
  end

  // Round half-up, arithmetic shift, saturate to 16 bits, optional ReLU.
  always_comb begin
    rnd_s     = $signed({acc_next_s[ACC_WIDTH-1], acc_next_s}) + RND_ADD;
    r_s       = rnd_s >>> SHIFT;
    sat_pos_s = (r_s > SAT_MAX);
    sat_neg_s = (r_s < SAT_MIN);
    if (sat_pos_s) begin
      clip_s = 16'sh7fff;
    end else if (sat_neg_s) begin
      clip_s = 16'sh8000;
    end else begin
      clip_s = r_s[15:0];
    end
    if ((RELU != 0) && clip_s[15]) begin
      q_s = 16'sd0;
    end else begin
      q_s = clip_s;
    end
  end

  // Term counter and running accumulator.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_r <= CNT_ZERO;
      acc_r <= '0;
    end else if (accept_s) begin
      acc_r <= acc_next_s;
      if (last_s) begin
        cnt_r <= CNT_ZERO;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  // Output register: a new result may replace the one drained this cycle.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_data_r  <= 16'sd0;
      out_valid_r <= 1'b0;
    end else if (load_s) begin
      out_data_r  <= q_s;
      out_valid_r <= 1'b1;
    end else if (out_valid_r && bus.out_tready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Sticky saturation flag; a new saturation beats a same-cycle clear.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      sat_flag_r <= 1'b0;
    end else if (load_s && (sat_pos_s || sat_neg_s)) begin
      sat_flag_r <= 1'b1;
    end else if (bus.sat_clr) begin
      sat_flag_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv1d_acc_requant.sv
// Directed and randomized checks of conv1d_acc_requant: one instance with
// default parameters and one configured KSIZE=1, SHIFT=8, RELU=0 for rounding.
module tb_conv1d_acc_requant;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  conv1d_acc_requant_if ifa ();
  conv1d_acc_requant_if ifb ();

  conv1d_acc_requant dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .bus      (ifa.slave)
  );

  conv1d_acc_requant #(.KSIZE(1), .ACC_WIDTH(40), .SHIFT(8), .RELU(0)) dut_r (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .bus      (ifb.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed=timeout expected=handshake", tag);
  endtask

  // Called #1 after an edge; returns #1 after the edge that accepted p.
  task automatic push_a(input int p, input int b);
    int n = 0;
    ifa.prod_tvalid = 1'b1;
    ifa.prod_tdata  = p;
    ifa.bias        = b;
    #1;
    while (!ifa.prod_tready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) fail_now("push_a");
    @(posedge clk); #1;
    ifa.prod_tvalid = 1'b0;
  endtask

  task automatic push_b(input int p, input int b);
    int n = 0;
    ifb.prod_tvalid = 1'b1;
    ifb.prod_tdata  = p;
    ifb.bias        = b;
    #1;
    while (!ifb.prod_tready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) fail_now("push_b");
    @(posedge clk); #1;
    ifb.prod_tvalid = 1'b0;
  endtask

  task automatic group_a(input int p, input int cnt, input int b);
    for (int i = 0; i < cnt; i++) push_a(p, b);
  endtask

  function automatic logic signed [15:0] ref_q(input longint s, input int sh, input bit relu);
    longint r;
    if (sh > 0) r = (s + (longint'(1) << (sh - 1))) >>> sh;
    else        r = s;
    if (r > 32767)       r = 32767;
    else if (r < -32768) r = -32768;
    if (relu && r < 0)   r = 0;
    return 16'(r);
  endfunction

  logic signed [15:0] expq[$];
  longint macc = 0;
  int     mcnt = 0;
  int     pd, bd;

  initial begin
    ifa.prod_tvalid = 1'b0; ifa.prod_tdata = 32'sd0; ifa.bias = 32'sd0;
    ifa.out_tready  = 1'b1; ifa.sat_clr = 1'b0;
    ifb.prod_tvalid = 1'b0; ifb.prod_tdata = 32'sd0; ifb.bias = 32'sd0;
    ifb.out_tready  = 1'b1; ifb.sat_clr = 1'b0;

    // Reset state
    #12;
    check("rst_ready",  ifa.prod_tready, 0);
    check("rst_valid",  ifa.out_tvalid, 0);
    check("rst_data",   ifa.out_tdata, 0);
    check("rst_sat",    ifa.sat_flag, 0);
    check("rst_ready_b", ifb.prod_tready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", ifa.prod_tready, 1);

    // Rounding on the KSIZE=1 instance
    push_b(384, 0);   check("rnd_384", ifb.out_tdata, 2);
    check("rnd_valid", ifb.out_tvalid, 1);
    push_b(-384, 0);  check("rnd_m384", ifb.out_tdata, -1);
    push_b(-385, 0);  check("rnd_m385", ifb.out_tdata, -2);
    push_b(127, 0);   check("rnd_127", ifb.out_tdata, 0);
    check("rnd_nosat", ifb.sat_flag, 0);
    push_b(0, 128);   check("rnd_bias128", ifb.out_tdata, 1);
    push_b(32'sh80000000, 0);
    check("rnd_negsat", ifb.out_tdata, -32768);
    check("rnd_negsat_flag", ifb.sat_flag, 1);

    // Basic sum
    group_a(256, 5, 0);
    check("basic_valid", ifa.out_tvalid, 1);
    check("basic_data", ifa.out_tdata, 5);
    check("basic_sat", ifa.sat_flag, 0);
    @(posedge clk); #1;
    check("basic_drain", ifa.out_tvalid, 0);

    // Saturation and ReLU
    group_a(1 << 24, 5, 0);
    check("sat_pos", ifa.out_tdata, 32767);
    check("sat_pos_flag", ifa.sat_flag, 1);
    ifa.sat_clr = 1'b1; @(posedge clk); #1; ifa.sat_clr = 1'b0;
    check("sat_clr", ifa.sat_flag, 0);
    group_a(-(1 << 24), 5, 0);
    check("relu_neg", ifa.out_tdata, 0);
    check("relu_neg_flag", ifa.sat_flag, 1);
    ifa.sat_clr = 1'b1; @(posedge clk); #1; ifa.sat_clr = 1'b0;
    check("sat_clr2", ifa.sat_flag, 0);
    group_a(1 << 24, 4, 0);
    ifa.sat_clr = 1'b1;
    push_a(1 << 24, 0);
    ifa.sat_clr = 1'b0;
    check("set_beats_clr", ifa.sat_flag, 1);
    check("set_beats_clr_data", ifa.out_tdata, 32767);
    @(posedge clk); #1;

    // Backpressure
    ifa.out_tready = 1'b0;
    group_a(256, 5, 0);
    check("bp_first", ifa.out_tdata, 5);
    group_a(512, 4, 0);
    check("bp_hold_valid", ifa.out_tvalid, 1);
    check("bp_hold_data", ifa.out_tdata, 5);
    ifa.prod_tvalid = 1'b1; ifa.prod_tdata = 512;
    #1;
    check("bp_stall", ifa.prod_tready, 0);
    @(posedge clk); #1;
    check("bp_stall2", ifa.prod_tready, 0);
    check("bp_stall_data", ifa.out_tdata, 5);
    ifa.out_tready = 1'b1;
    #1;
    check("bp_release", ifa.prod_tready, 1);
    @(posedge clk); #1;
    ifa.prod_tvalid = 1'b0;
    check("bp_second_valid", ifa.out_tvalid, 1);
    check("bp_second_data", ifa.out_tdata, 10);
    @(posedge clk); #1;
    check("bp_second_drain", ifa.out_tvalid, 0);

    // Reset mid-group
    group_a(1000, 3, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", ifa.out_tvalid, 0);
    check("mid_rst_data", ifa.out_tdata, 0);
    check("mid_rst_sat", ifa.sat_flag, 0);
    check("mid_rst_ready", ifa.prod_tready, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    group_a(256, 5, 0);
    check("mid_rst_regroup", ifa.out_tdata, 5);
    @(posedge clk); #1;

    // Random traffic against the reference arithmetic
    for (int c = 0; c < 12000; c++) begin
      pd = int'($urandom_range(0, 2097151)) - 1048576;
      if ($urandom_range(0, 19) == 0) pd = int'($urandom);
      bd = int'($urandom_range(0, 16777215)) - 8388608;
      ifa.prod_tvalid = ($urandom_range(0, 9) < 9);
      ifa.prod_tdata  = pd;
      ifa.bias        = bd;
      ifa.out_tready  = ($urandom_range(0, 3) != 0);
      #1;
      if (ifa.out_tvalid && ifa.out_tready) begin
        if (expq.size() == 0) fail_now("rand_spurious");
        else check("rand_out", ifa.out_tdata, expq.pop_front());
      end
      if (ifa.prod_tvalid && ifa.prod_tready) begin
        if (mcnt == 0) macc = longint'(bd) + longint'(pd);
        else           macc = macc + longint'(pd);
        if (mcnt == 4) begin
          expq.push_back(ref_q(macc, 8, 1'b1));
          mcnt = 0;
        end else begin
          mcnt++;
        end
      end
      @(posedge clk); #1;
    end
    ifa.prod_tvalid = 1'b0;
    ifa.out_tready  = 1'b1;
    #1;
    if (ifa.out_tvalid) begin
      if (expq.size() == 0) fail_now("rand_tail_spurious");
      else check("rand_tail", ifa.out_tdata, expq.pop_front());
    end
    @(posedge clk); #1;
    check("rand_empty_valid", ifa.out_tvalid, 0);
    check("rand_no_dropped", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
